// File: rtl/ifu_prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_prefetch_pkg
//  Brief    : Shared widths, reset vector and helpers for the prefetch IFU.
//  Revision : 1.0 - initial release
// ============================================================================
package ifu_prefetch_pkg;

    localparam int          c_INST_WIDTH = 32;
    localparam int          c_IMM_WIDTH  = 64;
    localparam logic [63:0] c_RESET_PC   = 64'h8000_0000;
    localparam int          c_INST_BYTES = 4;

    // Width of a counter that must hold every value from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fifo
//  Brief    : Synchronous FIFO with flush and occupancy output. Head data is
//             presented combinationally from storage (show-ahead).
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic                        empty,
    output logic                        full,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CW'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // Storage array; contents beyond the occupancy are don't-care.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_prefetch
//  Brief    : Decoupled instruction-fetch front end. Issues sequential fetch
//             requests under a credit limit, buffers returned instructions
//             with their PCs and discards responses owed to a flushed stream.
//             Optional macro IFU_PREFETCH_BYPASS_EN lets a response reach
//             decode in its arrival cycle when the queue is empty.
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int              XLEN     = c_IMM_WIDTH,
    parameter int              ILEN     = c_INST_WIDTH,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc
);

    localparam int c_CW = cnt_width(DEPTH);
    localparam int c_QW = ILEN + XLEN;

    logic [XLEN-1:0] r_pc;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_CW-1:0] w_inflight_next;
    logic            w_credit;
    logic            w_req_fire;
    logic            w_resp_ok;
    logic            w_resp_drop;
    logic            w_resp_keep;

    logic [c_QW-1:0] w_q_head;
    logic            w_q_empty;
    logic            w_q_full;
    logic            w_q_push;
    logic            w_q_pop;
    logic [c_CW-1:0] w_q_count;

    logic [XLEN-1:0] w_pcf_head;
    logic            w_pcf_empty;
    logic            w_pcf_full;
    logic            w_pcf_pop;
    logic [c_CW-1:0] w_pcf_count;

    // Credit covers every response memory still owes (dropped or not) plus
    // everything buffered, so the queue can never overflow.
    assign w_credit = ({1'b0, r_inflight} + {1'b0, w_q_count}) < (c_CW+1)'(DEPTH);

    assign imem_req_valid = !rst && w_credit;
    assign imem_req_addr  = r_pc;
    assign pc             = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp_ok       = imem_resp_valid && (r_inflight != '0);
    assign w_resp_drop     = (r_drop_cnt != '0);
    assign w_resp_keep     = w_resp_ok && !w_resp_drop && !redirect_valid;
    assign w_pcf_pop       = w_resp_ok && !w_resp_drop;
    assign w_inflight_next = r_inflight + c_CW'(w_req_fire) - c_CW'(w_resp_ok);
    assign w_q_pop         = !w_q_empty && inst_ready;

    // PCs of live outstanding requests, in request order.
    ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_req_fire),
        .push_data (r_pc),
        .pop       (w_pcf_pop),
        .head_data (w_pcf_head),
        .empty     (w_pcf_empty),
        .full      (w_pcf_full),
        .count     (w_pcf_count)
    );

    // Returned instructions paired with their fetch PCs, waiting for decode.
    ifu_fifo #(
        .WIDTH (c_QW),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_q_push),
        .push_data ({imem_resp_inst, w_pcf_head}),
        .pop       (w_q_pop),
        .head_data (w_q_head),
        .empty     (w_q_empty),
        .full      (w_q_full),
        .count     (w_q_count)
    );

    // Decode-side outputs and queue write enable (optionally bypassing).
    always_comb begin
        inst_valid = !rst && !w_q_empty;
        inst       = w_q_head[c_QW-1 -: ILEN];
        inst_pc    = w_q_head[XLEN-1:0];
        w_q_push   = w_resp_keep;
`ifdef IFU_PREFETCH_BYPASS_EN
        if (w_q_empty && w_resp_keep) begin
            inst_valid = !rst;
            inst       = imem_resp_inst;
            inst_pc    = w_pcf_head;
            w_q_push   = !inst_ready;
        end
`endif
    end

    // Fetch PC: redirect wins over sequential advance; wraps modulo 2^XLEN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_req_fire) begin
            r_pc <= r_pc + XLEN'(c_INST_BYTES);
        end
    end

    // Outstanding-request and drop counters; on redirect every response
    // still owed after this cycle belongs to the flushed stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (redirect_valid) begin
                r_drop_cnt <= w_inflight_next;
            end else if (w_resp_ok && w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - c_CW'(1);
            end
        end
    end

    // Simulation-only protocol and consistency checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && (r_inflight == '0)));
            assert (!(w_q_push && w_q_full));
            assert (!(w_pcf_pop && w_pcf_empty && !redirect_valid));
            assert (!(w_req_fire && w_pcf_full && !redirect_valid));
            assert (w_pcf_count == (r_inflight - r_drop_cnt));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifu_prefetch
//  Brief    : Self-checking bench for ifu_prefetch with a request-queue memory
//             model and a stream-level model of what decode must observe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;

`ifdef IFU_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_inst  = '0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] pc;

    ifu_prefetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          ep;
        int          cyc;
    } req_t;

    req_t        memq[$];
    int          cyc      = 0;
    int          lat      = 1;
    bit          rnd      = 1'b0;
    int          epoch    = 0;
    int          buffered = 0;
    logic [63:0] exp_pc   = 64'h8000_0000;
    logic [63:0] exp_req  = 64'h8000_0000;
    int          checks   = 0;
    int          errors   = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory: answers the oldest request once its latency has elapsed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst && memq.size() > 0 && (memq[0].cyc + lat <= cyc) &&
            (!rnd || $urandom_range(0, 3) != 0)) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
        end
    end

    // Stream model and per-cycle comparison.
    always @(negedge clk) begin
        bit keep;
        bit consume;
        if (rst) begin
            memq.delete();
            buffered = 0;
            exp_pc   = 64'h8000_0000;
            exp_req  = 64'h8000_0000;
        end else begin
            keep    = imem_resp_valid && memq.size() > 0 && memq[0].ep == epoch && !redirect_valid;
            consume = inst_valid && inst_ready && !redirect_valid;
            chk("credit", {63'd0, imem_req_valid}, {63'd0, (memq.size() + buffered) < DEPTH});
            chk("req_addr", imem_req_addr, exp_req);
            chk("pc_out", pc, exp_req);
            chk("inst_valid", {63'd0, inst_valid}, {63'd0, (buffered > 0) || (BYP && keep)});
            if (consume) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst", {32'd0, inst}, {32'd0, inst_of(exp_pc)});
                exp_pc = exp_pc + 64'd4;
            end
            if (imem_resp_valid && memq.size() > 0) begin
                if (keep) buffered++;
                void'(memq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                memq.push_back('{addr: imem_req_addr, ep: epoch, cyc: cyc});
                exp_req = exp_req + 64'd4;
            end
            if (consume) buffered--;
            if (redirect_valid) begin
                epoch++;
                buffered = 0;
                exp_pc   = redirect_pc;
                exp_req  = redirect_pc;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_inst(input string nm, input logic [63:0] exp);
        int n = 0;
        while (n < 40) begin
            nxt();
            @(negedge clk);
            if (inst_valid) break;
            n++;
        end
        chk({nm, "_valid"}, {63'd0, inst_valid}, 64'd1);
        chk({nm, "_pc"}, inst_pc, exp);
    endtask

    task automatic drain_and_set_lat(input int l);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        repeat (14) nxt();
        lat            = l;
        imem_req_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_addr", imem_req_addr, 64'h8000_0000);
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);

        // Streaming: memory 1-cycle latency, decode always ready.
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("c1_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("c1_addr", imem_req_addr, 64'h8000_0000);
        chk("c1_inst_valid", {63'd0, inst_valid}, 64'd0);
        nxt(); @(negedge clk);
        chk("c2_addr", imem_req_addr, 64'h8000_0004);
        chk("c2_inst_valid", {63'd0, inst_valid}, {63'd0, BYP});
        nxt(); @(negedge clk);
        chk("c3_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("c3_inst_pc", inst_pc, BYP ? 64'h8000_0004 : 64'h8000_0000);
        repeat (12) nxt();

        // Decode stall fills the queue and stops requests.
        inst_ready = 1'b0;
        repeat (10) nxt();
        @(negedge clk);
        chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("stall_inst_valid", {63'd0, inst_valid}, 64'd1);
        nxt(); inst_ready = 1'b1;
        @(negedge clk);
        chk("release_req_valid", {63'd0, imem_req_valid}, 64'd0);
        nxt(); @(negedge clk);
        chk("resume_req_valid", {63'd0, imem_req_valid}, 64'd1);
        repeat (8) nxt();

        // Redirect with three requests outstanding at long latency.
        drain_and_set_lat(6);
        nxt(); nxt();
        nxt(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        nxt(); imem_req_ready = 1'b1; redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("redir_addr", imem_req_addr, 64'h8000_1000);
        wait_inst("redir_first", 64'h8000_1000);
        repeat (10) nxt();

        // Redirect coinciding with a request fire and a response.
        drain_and_set_lat(1);
        repeat (6) nxt();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        @(negedge clk);
        chk("same_req_valid", {63'd0, imem_req_valid}, 64'd1);
        nxt(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("same_addr", imem_req_addr, 64'h8000_2000);
        wait_inst("same_first", 64'h8000_2000);
        repeat (6) nxt();

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        nxt(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        nxt(); @(negedge clk);
        chk("wrap_addr1", imem_req_addr, 64'h0);
        repeat (8) nxt();

        // Mixed traffic with backpressure on both sides and redirects.
        drain_and_set_lat(2);
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            nxt();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = {$urandom(), $urandom()} & ~64'h3;
        end
        nxt();
        rnd = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (20) nxt();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with an in-order prefetch queue. It generalises the single-cycle `inst`-in / `pc`-out fetch path into a decoupled front end. It issues sequential fetch requests to instruction memory over a valid/ready handshake and buffers up to `DEPTH` returned instructions together with their PCs. It hands instructions to decode over a second valid/ready handshake and flushes cleanly on a redirect from execute.

## Interface
Parameters:
- `XLEN`, 64, PC/address width (matches `ImmWidth`).
- `ILEN`, 32, instruction width (matches `InstWidth`).
- `DEPTH`, 4, queue entries and maximum in-flight requests; power of two, ≥2.
- `RESET_PC`, 64'h8000_0000, first fetch address.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  fetch address (= `pc`).
- `imem_resp_valid`  in  1  one instruction returned, in request order.
- `imem_resp_inst`  in  ILEN  returned instruction.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  XLEN  restart address, 4-byte aligned.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode consumes head.
- `inst`  out  ILEN  head instruction.
- `inst_pc`  out  XLEN  PC of head instruction.
- `pc`  out  XLEN  next address to request.

## Operation
- State:
  - `pc`.
  - Queue of {inst, pc}.
  - `inflight` counter (0..DEPTH): accepted requests whose responses are not yet back.
  - `drop_cnt` counter: in-flight responses to discard.
- Request credit: `imem_req_valid = !rst && (inflight + occupancy < DEPTH)`. `imem_req_valid` does not depend on `redirect_valid`.
- Request fire (`valid && ready`): `pc <= pc + 4` (modulo 2^XLEN, wraps silently). `inflight` increments.
- Response handling: `inflight` decrements on each response.
  - If `drop_cnt > 0`: `drop_cnt` decrements and the response is discarded.
  - Otherwise: {`imem_resp_inst`, its request PC} is pushed to the queue. The request PC comes from a `DEPTH`-entry PC FIFO written on request fire.
- Consume: `inst_valid && inst_ready` pops the head.
- Redirect (highest priority):
  - Queue and PC FIFO contents flushed.
  - `pc <= redirect_pc`.
  - `drop_cnt <= inflight_next`, where `inflight_next = inflight + req_fire − resp_valid`.
  - A request firing in the redirect cycle is accepted by memory, but its response is dropped.
  - A response arriving in the redirect cycle is dropped.
  - A consume in the redirect cycle is harmless; the head is flushed anyway.
- Overflow cannot occur: credit counts in-flight (including to-be-dropped) responses plus occupancy.
- `imem_resp_valid` with `inflight == 0` is a protocol violation, flagged by a simulation assertion. State is unchanged.

## Timing
- Reset values:
  - `pc = imem_req_addr = RESET_PC`.
  - `imem_req_valid = 0` during reset.
  - `inst_valid = 0`.
  - `inflight = drop_cnt = 0`, queue empty.
  - `inst` and `inst_pc` are don't-care while `inst_valid = 0`.
- First request is valid in the first cycle after `rst` deasserts.
- Request throughput: 1 per cycle while credit is available.
- Memory response latency: ≥1 cycle after request fire.
- Response to `inst_valid`:
  - 1 cycle through the queue (registered).
  - 0 cycles when bypass is enabled (see Configuration).
- Queue full and consume in the same cycle: no response can arrive, because credit is exhausted. Push and pop may coincide when not full.
- First request to `redirect_pc` is valid the cycle after the redirect, provided credit is available.
- `rst` mid-operation discards everything. Any responses still owed by memory are the memory's responsibility to squash.

## Configuration
- `IFU_PREFETCH_BYPASS_EN`
  - Defined: when the queue is empty and an undropped response arrives, it drives `inst`/`inst_pc`/`inst_valid` combinationally in the same cycle. If `inst_ready` is high, it is not written to the queue. Redirect still suppresses it.
  - Undefined: every instruction passes through the queue, giving a minimum 1-cycle response-to-`inst_valid` latency and fully registered outputs.

## Structure
- Shared package / `include/defines.v`: `InstWidth`, `ImmWidth`, `RESET_PC` value, `INST_BYTES = 4`.
- Sub-module `ifu_fifo`: synchronous FIFO parametrised in width and depth, with flush input and occupancy output. It is instantiated twice: instruction+PC queue and request-PC FIFO.
- Counters and credit logic live in `ifu_prefetch`.

## Test plan
- Reset, memory always ready with 1-cycle latency, decode always ready:
  - requests to 0x80000000, 0x80000004, …;
  - `inst_pc` sequence matches, one instruction per cycle after a 2-cycle pipeline fill.
- Decode stalled (`inst_ready = 0`):
  - after 4 accepted requests `imem_req_valid` drops;
  - queue holds 4;
  - releasing `inst_ready` drains in order, and requests resume 1 cycle after the first pop.
- Redirect to 0x80001000 with 3 requests in flight:
  - next 3 responses are discarded;
  - first `inst_valid` shows `inst_pc = 0x80001000`.
- Redirect in the same cycle as a request fire and a response:
  - both responses are dropped;
  - `drop_cnt` is correct, and no stale PC reaches decode.
- `pc` at 0xFFFF_FFFF_FFFF_FFFC: next request address is 0x0.
- With `IFU_PREFETCH_BYPASS_EN` and the queue empty: response at cycle N appears on `inst` in cycle N. Without the macro it appears in cycle N+1.
